// File: rtl/rca_config_unit_pkg.sv
// rtl/rca_config_unit_pkg.sv - shared constants, opcode enum and request struct for the RCA config unit
package rca_config;

    localparam int NUM_RCAS               = 4;
    localparam int NUM_READ_PORTS         = 5;
    localparam int NUM_WRITE_PORTS        = 5;
    localparam int NUM_IO_UNITS           = 14;
    localparam int GRID_MUX_COUNT         = 72;
    localparam int GRID_MUX_INPUTS        = 8;
    localparam int IO_UNIT_MUX_INPUTS     = 16;
    localparam int UNUSED_WRITE_PORT_ADDR = 14;

    localparam int REG_ADDR_W = 5;
    localparam int RES_SEL_W  = $clog2(NUM_IO_UNITS + 1);
    localparam int GRID_SEL_W = $clog2(GRID_MUX_INPUTS);
    localparam int IO_SEL_W   = $clog2(IO_UNIT_MUX_INPUTS);
    localparam int RCA_IDX_W  = $clog2(NUM_RCAS);

    typedef enum logic [2:0] {
        USE_FB   = 3'd0,
        CPU_REG  = 3'd1,
        GRID_MUX = 3'd2,
        IO_MUX   = 3'd3,
        RES_MUX  = 3'd4,
        IO_USE   = 3'd5,
        USE_NFB  = 3'd6
    } rca_cfg_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COMMIT
    } rca_cfg_state_t;

    // Only the operand bits any config op can look at are kept.
    typedef struct packed {
        rca_cfg_op_t op;
        logic [6:0]  funct7;
        logic [6:0]  rs1;
        logic [4:0]  rs2;
    } rca_cfg_req_t;

endpackage

// File: rtl/rca_config_unit_if.sv
// rtl/rca_config_unit_if.sv - issue handshake and completion report between decoder and config unit
interface rca_config_unit_if #(
    parameter int ID_W = 3
);
    logic            issue_valid;
    logic            issue_ready;
    logic [2:0]      issue_funct3;
    logic [6:0]      issue_funct7;
    logic [31:0]     issue_rs1;
    logic [31:0]     issue_rs2;
    logic [ID_W-1:0] issue_id;
    logic            cfg_done;
    logic [ID_W-1:0] cfg_done_id;
    logic            cfg_err;

    modport master (
        output issue_valid, issue_funct3, issue_funct7, issue_rs1, issue_rs2, issue_id,
        input  issue_ready, cfg_done, cfg_done_id, cfg_err
    );

    modport slave (
        input  issue_valid, issue_funct3, issue_funct7, issue_rs1, issue_rs2, issue_id,
        output issue_ready, cfg_done, cfg_done_id, cfg_err
    );
endinterface

// File: rtl/rca_config_unit_legality_check.sv
// rtl/rca_config_unit_legality_check.sv - combinational legality check of a captured config request
module rca_cfg_legality_check
    import rca_config::*;
(
    input  rca_cfg_req_t req,
    output logic         illegal
);

    always_comb begin
        illegal = 1'b0;
        if (req.funct7 >= 7'(NUM_RCAS)) begin
            illegal = 1'b1;
        end
        case (req.op)
            CPU_REG: begin
                if (req.rs1[3] ? (req.rs1[2:0] >= 3'(NUM_WRITE_PORTS))
                               : (req.rs1[2:0] >= 3'(NUM_READ_PORTS))) begin
                    illegal = 1'b1;
                end
            end
            GRID_MUX: if (req.rs1[6:0] >= 7'(GRID_MUX_COUNT)) illegal = 1'b1;
            IO_MUX:   if (req.rs1[3:0] >= 4'(NUM_IO_UNITS))   illegal = 1'b1;
            RES_MUX: begin
                if ((req.rs1[2:0] >= 3'(NUM_WRITE_PORTS)) ||
                    (req.rs2[3:0] > 4'(UNUSED_WRITE_PORT_ADDR))) begin
                    illegal = 1'b1;
                end
            end
            IO_USE:  ;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rca_config_unit.sv
// rtl/rca_config_unit.sv - commits RCA config instructions once the target RCA is idle; optional RCA_CFG_STALL_COUNT_EN adds a stall counter
module rca_config_unit
    import rca_config::*;
#(
    parameter int ID_W = 3
) (
    input  logic                                              clk,
    input  logic                                              rst,
    rca_config_unit_if.slave                                  bus,
    input  logic [NUM_RCAS-1:0]                               rca_busy,
    output logic [NUM_RCAS-1:0]                               cfg_lock,
    output logic [NUM_RCAS*NUM_READ_PORTS*REG_ADDR_W-1:0]     src_addr,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0]    dst_addr_fb,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0]    dst_addr_nfb,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_SEL_W-1:0]     res_sel_fb,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_SEL_W-1:0]     res_sel_nfb,
    output logic [NUM_RCAS*NUM_READ_PORTS-1:0]                io_use,
    output logic                                              grid_wr,
    output logic [RCA_IDX_W-1:0]                              grid_wr_rca,
    output logic [6:0]                                        grid_wr_idx,
    output logic [GRID_SEL_W-1:0]                             grid_wr_sel,
    output logic                                              iomux_wr,
    output logic [RCA_IDX_W-1:0]                              iomux_wr_rca,
    output logic [3:0]                                        iomux_wr_idx,
    output logic [IO_SEL_W-1:0]                               iomux_wr_sel
`ifdef RCA_CFG_STALL_COUNT_EN
    ,
    output logic [31:0]                                       cfg_stall_cycles
`endif
);

    rca_cfg_state_t        state, state_next;
    rca_cfg_req_t          req_q;
    logic [ID_W-1:0]       id_q;
    logic                  illegal;
    logic                  accept;
    logic                  commit_go;
    logic [RCA_IDX_W-1:0]  tgt_q;
    logic [RCA_IDX_W-1:0]  lock_tgt;

    logic [REG_ADDR_W-1:0]     src_q     [NUM_RCAS][NUM_READ_PORTS];
    logic [REG_ADDR_W-1:0]     dst_fb_q  [NUM_RCAS][NUM_WRITE_PORTS];
    logic [REG_ADDR_W-1:0]     dst_nfb_q [NUM_RCAS][NUM_WRITE_PORTS];
    logic [RES_SEL_W-1:0]      res_fb_q  [NUM_RCAS][NUM_WRITE_PORTS];
    logic [RES_SEL_W-1:0]      res_nfb_q [NUM_RCAS][NUM_WRITE_PORTS];
    logic [NUM_READ_PORTS-1:0] io_use_q  [NUM_RCAS];

    assign tgt_q    = req_q.funct7[RCA_IDX_W-1:0];
    assign lock_tgt = accept ? bus.issue_funct7[RCA_IDX_W-1:0] : tgt_q;

    rca_cfg_legality_check u_legality (
        .req     (req_q),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Illegal requests skip the busy wait; they only need to report the error.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit_go  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.issue_valid) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (illegal || !rca_busy[tgt_q]) begin
                    commit_go  = 1'b1;
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q           <= '0;
            id_q            <= '0;
            bus.issue_ready <= 1'b1;
            bus.cfg_done    <= 1'b0;
            bus.cfg_done_id <= '0;
            bus.cfg_err     <= 1'b0;
            cfg_lock        <= '0;
            grid_wr         <= 1'b0;
            grid_wr_rca     <= '0;
            grid_wr_idx     <= '0;
            grid_wr_sel     <= '0;
            iomux_wr        <= 1'b0;
            iomux_wr_rca    <= '0;
            iomux_wr_idx    <= '0;
            iomux_wr_sel    <= '0;
            for (int r = 0; r < NUM_RCAS; r++) begin
                io_use_q[r] <= '0;
                for (int p = 0; p < NUM_READ_PORTS; p++) src_q[r][p] <= '0;
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    dst_fb_q[r][p]  <= '0;
                    dst_nfb_q[r][p] <= '0;
                    res_fb_q[r][p]  <= RES_SEL_W'(UNUSED_WRITE_PORT_ADDR);
                    res_nfb_q[r][p] <= RES_SEL_W'(UNUSED_WRITE_PORT_ADDR);
                end
            end
        end else begin
            bus.issue_ready <= (state_next == ST_IDLE);
            cfg_lock        <= (state_next == ST_WAIT) ? (NUM_RCAS'(1) << lock_tgt) : '0;
            bus.cfg_done    <= 1'b0;
            bus.cfg_err     <= 1'b0;
            grid_wr         <= 1'b0;
            iomux_wr        <= 1'b0;
            if (accept) begin
                req_q.op     <= rca_cfg_op_t'(bus.issue_funct3);
                req_q.funct7 <= bus.issue_funct7;
                req_q.rs1    <= bus.issue_rs1[6:0];
                req_q.rs2    <= bus.issue_rs2[4:0];
                id_q         <= bus.issue_id;
            end
            // Writes land on entry to COMMIT so they are visible alongside cfg_done.
            if (commit_go) begin
                bus.cfg_done    <= 1'b1;
                bus.cfg_done_id <= id_q;
                bus.cfg_err     <= illegal;
                if (!illegal) begin
                    case (req_q.op)
                        CPU_REG: begin
                            if (!req_q.rs1[3])     src_q[tgt_q][req_q.rs1[2:0]]     <= req_q.rs2[4:0];
                            else if (req_q.rs1[4]) dst_fb_q[tgt_q][req_q.rs1[2:0]]  <= req_q.rs2[4:0];
                            else                   dst_nfb_q[tgt_q][req_q.rs1[2:0]] <= req_q.rs2[4:0];
                        end
                        GRID_MUX: begin
                            grid_wr     <= 1'b1;
                            grid_wr_rca <= tgt_q;
                            grid_wr_idx <= req_q.rs1[6:0];
                            grid_wr_sel <= req_q.rs2[GRID_SEL_W-1:0];
                        end
                        IO_MUX: begin
                            iomux_wr     <= 1'b1;
                            iomux_wr_rca <= tgt_q;
                            iomux_wr_idx <= req_q.rs1[3:0];
                            iomux_wr_sel <= req_q.rs2[IO_SEL_W-1:0];
                        end
                        RES_MUX: begin
                            if (req_q.rs1[3]) res_fb_q[tgt_q][req_q.rs1[2:0]]  <= req_q.rs2[RES_SEL_W-1:0];
                            else              res_nfb_q[tgt_q][req_q.rs1[2:0]] <= req_q.rs2[RES_SEL_W-1:0];
                        end
                        IO_USE:  io_use_q[tgt_q] <= req_q.rs1[NUM_READ_PORTS-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RCAS; r++) begin : g_rca
        assign io_use[r*NUM_READ_PORTS +: NUM_READ_PORTS] = io_use_q[r];
        for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
            assign src_addr[(r*NUM_READ_PORTS+p)*REG_ADDR_W +: REG_ADDR_W] = src_q[r][p];
        end
        for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_wr
            assign dst_addr_fb[(r*NUM_WRITE_PORTS+p)*REG_ADDR_W +: REG_ADDR_W]  = dst_fb_q[r][p];
            assign dst_addr_nfb[(r*NUM_WRITE_PORTS+p)*REG_ADDR_W +: REG_ADDR_W] = dst_nfb_q[r][p];
            assign res_sel_fb[(r*NUM_WRITE_PORTS+p)*RES_SEL_W +: RES_SEL_W]     = res_fb_q[r][p];
            assign res_sel_nfb[(r*NUM_WRITE_PORTS+p)*RES_SEL_W +: RES_SEL_W]    = res_nfb_q[r][p];
        end
    end

`ifdef RCA_CFG_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_stall_cycles <= '0;
        end else if ((state == ST_WAIT) && rca_busy[tgt_q] && (cfg_stall_cycles != '1)) begin
            cfg_stall_cycles <= cfg_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rca_config_unit.sv
// tb/tb_rca_config_unit.sv - scoreboard bench for rca_config_unit with directed vectors
module tb_rca_config_unit;
    import rca_config::*;

    localparam int ID_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_RCAS-1:0] rca_busy = '0;
    logic [NUM_RCAS-1:0] cfg_lock;
    logic [99:0] src_addr, dst_addr_fb, dst_addr_nfb;
    logic [79:0] res_sel_fb, res_sel_nfb;
    logic [19:0] io_use;
    logic        grid_wr, iomux_wr;
    logic [1:0]  grid_wr_rca, iomux_wr_rca;
    logic [6:0]  grid_wr_idx;
    logic [2:0]  grid_wr_sel;
    logic [3:0]  iomux_wr_idx, iomux_wr_sel;
`ifdef RCA_CFG_STALL_COUNT_EN
    logic [31:0] cfg_stall_cycles;
`endif

    rca_config_unit_if #(.ID_W(ID_W)) bus ();

    rca_config_unit #(.ID_W(ID_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .rca_busy     (rca_busy),
        .cfg_lock     (cfg_lock),
        .src_addr     (src_addr),
        .dst_addr_fb  (dst_addr_fb),
        .dst_addr_nfb (dst_addr_nfb),
        .res_sel_fb   (res_sel_fb),
        .res_sel_nfb  (res_sel_nfb),
        .io_use       (io_use),
        .grid_wr      (grid_wr),
        .grid_wr_rca  (grid_wr_rca),
        .grid_wr_idx  (grid_wr_idx),
        .grid_wr_sel  (grid_wr_sel),
        .iomux_wr     (iomux_wr),
        .iomux_wr_rca (iomux_wr_rca),
        .iomux_wr_idx (iomux_wr_idx),
        .iomux_wr_sel (iomux_wr_sel)
`ifdef RCA_CFG_STALL_COUNT_EN
        ,
        .cfg_stall_cycles (cfg_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [ID_W-1:0] id; logic err; } done_exp_t;
    typedef struct { bit io; logic [1:0] rca; logic [6:0] idx; logic [3:0] sel; } strb_exp_t;

    done_exp_t done_q[$];
    strb_exp_t strb_q[$];
    done_exp_t de;
    strb_exp_t se;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int last_done_cyc = -1;
    int last_grid_cyc = -1;
    int iomux_seen = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every completion and strobe against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cfg_done === 1'b1) begin
                done_count++;
                last_done_cyc = cyc;
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got id %0d err %0d, expected none", bus.cfg_done_id, bus.cfg_err);
                end else begin
                    de = done_q.pop_front();
                    if (bus.cfg_done_id !== de.id || bus.cfg_err !== de.err) begin
                        errors++;
                        $display("FAIL done_resp: got id %0d err %0d, expected id %0d err %0d",
                                 bus.cfg_done_id, bus.cfg_err, de.id, de.err);
                    end
                end
            end
            if (grid_wr === 1'b1 || iomux_wr === 1'b1) begin
                checks++;
                if (grid_wr === 1'b1) last_grid_cyc = cyc;
                if (iomux_wr === 1'b1) iomux_seen++;
                if (strb_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got grid %0b iomux %0b, expected none", grid_wr, iomux_wr);
                end else begin
                    se = strb_q.pop_front();
                    if (se.io ? (iomux_wr !== 1'b1 || grid_wr !== 1'b0 || iomux_wr_rca !== se.rca ||
                                 iomux_wr_idx !== se.idx[3:0] || iomux_wr_sel !== se.sel)
                              : (grid_wr !== 1'b1 || iomux_wr !== 1'b0 || grid_wr_rca !== se.rca ||
                                 grid_wr_idx !== se.idx || grid_wr_sel !== se.sel[2:0])) begin
                        errors++;
                        $display("FAIL strobe_fields: got grid %0b/%0d/%0d/%0d iomux %0b/%0d/%0d/%0d, expected io %0b rca %0d idx %0d sel %0d",
                                 grid_wr, grid_wr_rca, grid_wr_idx, grid_wr_sel,
                                 iomux_wr, iomux_wr_rca, iomux_wr_idx, iomux_wr_sel,
                                 se.io, se.rca, se.idx, se.sel);
                    end
                end
            end
        end
    end

    task automatic do_issue(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [ID_W-1:0] id, input logic exp_err,
                            input bit track);
        int n = 0;
        while (bus.issue_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("issue_ready_timeout", bus.issue_ready, 1'b1);
        bus.issue_funct3 = f3;
        bus.issue_funct7 = f7;
        bus.issue_rs1    = r1;
        bus.issue_rs2    = r2;
        bus.issue_id     = id;
        bus.issue_valid  = 1'b1;
        acc_cyc = cyc;
        if (track) done_q.push_back('{id: id, err: exp_err});
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", done_count, target);
    endtask

    logic [79:0] rs_reset;
    logic [31:0] stall0;
    int          acc1, d0;

    initial begin
        bus.issue_valid  = 1'b0;
        bus.issue_funct3 = '0;
        bus.issue_funct7 = '0;
        bus.issue_rs1    = '0;
        bus.issue_rs2    = '0;
        bus.issue_id     = '0;
        stall0           = '0;
        for (int i = 0; i < 20; i++) rs_reset[i*4 +: 4] = 4'd14;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_res_sel_fb", res_sel_fb, rs_reset);
        chk("rst_res_sel_nfb", res_sel_nfb, rs_reset);
        chk("rst_src_addr", src_addr, '0);
        chk("rst_dst_fb", dst_addr_fb, '0);
        chk("rst_dst_nfb", dst_addr_nfb, '0);
        chk("rst_io_use", io_use, '0);
        chk("rst_ready", bus.issue_ready, 1'b1);
        chk("rst_lock", cfg_lock, '0);
        chk("rst_strobes", {grid_wr, iomux_wr, bus.cfg_done, bus.cfg_err}, 4'b0);

        // CPU-reg writes: feedback dst, source, non-feedback dst
        do_issue(3'b001, 7'd2, 32'h1B, 32'd7, 3'd1, 1'b0, 1'b1);
        wait_done(1);
        chk("dst_fb_2_3", dst_addr_fb, 100'd7 << 65);
        chk("latency", last_done_cyc - acc_cyc, 2);
        do_issue(3'b001, 7'd0, 32'h11, 32'h1F, 3'd5, 1'b0, 1'b1);
        wait_done(2);
        chk("src_0_1", src_addr, 100'h1F << 5);
        chk("dst_fb_kept", dst_addr_fb, 100'd7 << 65);
        do_issue(3'b001, 7'd3, 32'h0C, 32'h11, 3'd6, 1'b0, 1'b1);
        wait_done(3);
        chk("dst_nfb_3_4", dst_addr_nfb, 100'h11 << 95);

        // Grid write held off by a busy RCA for 10 wait cycles
`ifdef RCA_CFG_STALL_COUNT_EN
        stall0 = cfg_stall_cycles;
`endif
        rca_busy = 4'b0010;
        strb_q.push_back('{io: 1'b0, rca: 2'd1, idx: 7'd71, sel: 4'd5});
        do_issue(3'b010, 7'd1, 32'd71, 32'd5, 3'd2, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("lock_while_busy", cfg_lock, 4'b0010);
            chk("no_grid_while_busy", grid_wr, 1'b0);
            @(negedge clk);
        end
        rca_busy = 4'b0000;
        wait_done(4);
        chk("grid_cycle", last_grid_cyc - acc_cyc, 12);
        chk("lock_dropped", cfg_lock, '0);
`ifdef RCA_CFG_STALL_COUNT_EN
        chk("stall_count", cfg_stall_cycles - stall0, 32'd10);
`endif

        // Illegal instructions and a boundary-legal IO-mux write
        do_issue(3'b011, 7'd0, 32'd14, 32'd3, 3'd3, 1'b1, 1'b1);
        wait_done(5);
        chk("no_iomux_on_err", iomux_seen, 0);
        do_issue(3'b101, 7'd5, 32'h1F, 32'd0, 3'd4, 1'b1, 1'b1);
        wait_done(6);
        chk("io_use_kept", io_use, '0);
        do_issue(3'b000, 7'd0, 32'd0, 32'd0, 3'd7, 1'b1, 1'b1);
        wait_done(7);
        strb_q.push_back('{io: 1'b1, rca: 2'd2, idx: 7'd13, sel: 4'd10});
        do_issue(3'b011, 7'd2, 32'd13, 32'hA, 3'd6, 1'b0, 1'b1);
        wait_done(8);
        chk("iomux_seen", iomux_seen, 1);

        // Result-MUX select, illegal select value, then reset while waiting
        do_issue(3'b100, 7'd0, 32'h0A, 32'd9, 3'd0, 1'b0, 1'b1);
        wait_done(9);
        chk("res_fb_0_2", res_sel_fb[11:8], 4'd9);
        do_issue(3'b100, 7'd0, 32'h02, 32'd15, 3'd1, 1'b1, 1'b1);
        wait_done(10);
        chk("res_nfb_kept", res_sel_nfb, rs_reset);
        rca_busy = 4'b0001;
        do_issue(3'b100, 7'd0, 32'h0A, 32'd3, 3'd2, 1'b0, 1'b0);
        chk("lock_before_rst", cfg_lock, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rca_busy = 4'b0000;
        d0 = done_count;
        repeat (5) @(negedge clk);
        chk("no_done_after_rst", done_count, d0);
        chk("res_fb_reset", res_sel_fb[11:8], 4'd14);
        chk("dst_fb_reset", dst_addr_fb, '0);
        chk("ready_after_rst", bus.issue_ready, 1'b1);

        // Back-to-back IO-use writes to RCA 3
        do_issue(3'b101, 7'd3, 32'h15, 32'd0, 3'd2, 1'b0, 1'b1);
        acc1 = acc_cyc;
        chk("ready_low_wait", bus.issue_ready, 1'b0);
        @(negedge clk);
        chk("ready_low_commit", bus.issue_ready, 1'b0);
        chk("io_use3_first", io_use[19:15], 5'h15);
        do_issue(3'b101, 7'd3, 32'h03, 32'd0, 3'd3, 1'b0, 1'b1);
        chk("accept_spacing", acc_cyc - acc1, 3);
        wait_done(d0 + 2);
        chk("io_use3_second", io_use[19:15], 5'h03);

        repeat (3) @(negedge clk);
        chk("done_q_empty", done_q.size(), 0);
        chk("strb_q_empty", strb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
